// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, state codes, mux selects, fault causes.
// Pure constants plus the ImmSrc decode helper; no timing or handshake behaviour of its own.
package ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_FAULT    = 4'd11;

  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_DATA   = 2'b01;
  localparam logic [1:0] RS_ALURES = 2'b10;

  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_RD1   = 2'b10;

  localparam logic [1:0] SB_RD2  = 2'b00;
  localparam logic [1:0] SB_IMM  = 2'b01;
  localparam logic [1:0] SB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the datapath/memory side (slave).
// Carries the opcode and mem_ready handshake in, all control strobes and selects out.
interface multicycle_control_fsm_if;

  logic [6:0] op;
  logic       mem_ready;
  logic       mem_req;
  logic       PCUpdate;
  logic       Branch;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       retire;
  logic       fault;
  logic [1:0] fault_cause;
  logic [3:0] state_o;

  modport master (
    input  op, mem_ready,
    output mem_req, PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, retire, fault, fault_cause, state_o
  );

  modport slave (
    output op, mem_ready,
    input  mem_req, PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, retire, fault, fault_cause, state_o
  );

endinterface

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts unanswered memory-wait cycles; timeout is combinational from the count (0 cycles latency).
// Counter saturates at WAIT_MAX; WAIT_MAX = 0 disables the timeout entirely.
module mem_wait_timer #(
  parameter int WAIT_MAX = 16,
  parameter int WAIT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic ready,
  output logic timeout
);

  localparam logic [WAIT_W-1:0] MAX = WAIT_W'(WAIT_MAX);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !ready && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = (WAIT_MAX != 0) && en && (cnt == MAX);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle RISC-V datapath: lw 5 cycles, sw/R/I/jal 4, beq 3 with mem_ready high.
// Memory states stall on mem_ready low; too many wait cycles or an illegal opcode park it in sticky FAULT.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_ITYPE = 1'b1,
  parameter bit SUPPORT_JAL   = 1'b1,
  parameter int WAIT_MAX      = 16,
  parameter int WAIT_W        = 5
) (
  input logic                     clk,
  input logic                     rst_n,
  multicycle_control_fsm_if.master bus
);

  logic [3:0] state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       timeout, mem_state;

  logic       mem_req_c, pcu_c, br_c, irw_c, rw_c, mw_c, retire_c, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

  // Clearing on every state change gives a fresh count on entry to each memory state.
  mem_wait_timer #(.WAIT_MAX(WAIT_MAX), .WAIT_W(WAIT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_d != state_q),
    .en      (mem_state),
    .ready   (bus.mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cause_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      if (state_d == S_FAULT && state_q != S_FAULT) cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = FC_NONE;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else if (timeout) begin state_d = S_FAULT; cause_d = FC_TIMEOUT; end
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = SUPPORT_ITYPE ? S_EXECUTEI : S_FAULT;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = SUPPORT_JAL ? S_JAL : S_FAULT;
          default:      state_d = S_FAULT;
        endcase
        cause_d = FC_ILLEGAL;
      end
      S_MEMADR:   state_d = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD, S_MEMWRITE: begin
        if (bus.mem_ready) state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
        else if (timeout) begin state_d = S_FAULT; cause_d = FC_TIMEOUT; end
      end
      S_MEMWB:    state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_c  = 1'b0;
    pcu_c      = 1'b0;
    br_c       = 1'b0;
    irw_c      = 1'b0;
    rw_c       = 1'b0;
    mw_c       = 1'b0;
    retire_c   = 1'b0;
    adr_src    = 1'b0;
    result_src = RS_ALUOUT;
    alu_src_a  = SA_PC;
    alu_src_b  = SB_RD2;
    alu_op     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_b  = SB_FOUR;
        result_src = RS_ALURES;
        irw_c      = bus.mem_ready;
        pcu_c      = bus.mem_ready;
      end
      S_DECODE:   begin alu_src_a = SA_OLDPC; alu_src_b = SB_IMM; end
      S_MEMADR:   begin alu_src_a = SA_RD1;   alu_src_b = SB_IMM; end
      S_MEMREAD:  begin mem_req_c = 1'b1; adr_src = 1'b1; end
      S_MEMWB:    begin result_src = RS_DATA; rw_c = 1'b1; retire_c = 1'b1; end
      S_MEMWRITE: begin mem_req_c = 1'b1; adr_src = 1'b1; mw_c = 1'b1; retire_c = bus.mem_ready; end
      S_EXECUTER: begin alu_src_a = SA_RD1; alu_src_b = SB_RD2; alu_op = ALU_FUNCT; end
      S_EXECUTEI: begin alu_src_a = SA_RD1; alu_src_b = SB_IMM; alu_op = ALU_FUNCT; end
      S_ALUWB:    begin rw_c = 1'b1; retire_c = 1'b1; end
      S_BEQ:      begin alu_src_a = SA_RD1; alu_op = ALU_SUB; br_c = 1'b1; retire_c = 1'b1; end
      S_JAL:      begin alu_src_a = SA_OLDPC; alu_src_b = SB_FOUR; pcu_c = 1'b1; end
      default:    ;
    endcase
  end

  // Reset lands in FETCH, whose Moore outputs would otherwise request memory while rst_n is low.
  assign bus.mem_req     = rst_n & mem_req_c;
  assign bus.PCUpdate    = rst_n & pcu_c;
  assign bus.Branch      = rst_n & br_c;
  assign bus.IRWrite     = rst_n & irw_c;
  assign bus.RegWrite    = rst_n & rw_c;
  assign bus.MemWrite    = rst_n & mw_c;
  assign bus.retire      = rst_n & retire_c;
  assign bus.AdrSrc      = adr_src;
  assign bus.ResultSrc   = result_src;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ALUOp       = alu_op;
  assign bus.ImmSrc      = imm_src(bus.op);
  assign bus.fault       = (state_q == S_FAULT);
  assign bus.fault_cause = cause_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Random instruction streams with planned memory waits; an instruction-level model predicts each
// retire/fault event (cycle, strobe counts, cause) into a queue that a negedge monitor drains.
module tb_multicycle_control_fsm;
  import ctrl_pkg::*;

  localparam int WMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_control_fsm_if bus ();
  multicycle_control_fsm_if bus2 ();

  multicycle_control_fsm #(.SUPPORT_ITYPE(1'b1), .SUPPORT_JAL(1'b1), .WAIT_MAX(WMAX), .WAIT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master));

  multicycle_control_fsm #(.SUPPORT_ITYPE(1'b0), .SUPPORT_JAL(1'b0), .WAIT_MAX(0), .WAIT_W(5)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2.master));

  typedef struct {
    int cyc;
    int is_fault;
    int cause;
    int irw, pcu, rw, mw, br;
    int rs;
  } exp_t;

  exp_t sbq[$];
  bit   rdy_plan[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int imm_exp(input logic [6:0] o);
    case (o)
      7'b0100011: return 1;
      7'b1100011: return 2;
      7'b1101111: return 3;
      default:    return 0;
    endcase
  endfunction

  // ---------------- monitor ----------------
  int n_irw, n_pcu, n_rw, n_mw, n_br;
  bit fault_seen;
  int held_cause;

  always @(negedge clk) begin
    int strobes;
    exp_t e;
    strobes = int'({bus.mem_req, bus.PCUpdate, bus.Branch, bus.IRWrite,
                    bus.RegWrite, bus.MemWrite, bus.retire});
    chk("immsrc", int'(bus.ImmSrc), imm_exp(bus.op));
    if (!rst_n) begin
      chk("reset_strobes", strobes, 0);
      chk("reset_state", int'(bus.state_o), int'(S_FETCH));
      chk("reset_fault", int'({bus.fault, bus.fault_cause}), 0);
      n_irw = 0; n_pcu = 0; n_rw = 0; n_mw = 0; n_br = 0;
      fault_seen = 1'b0;
    end else if (fault_seen) begin
      chk("fault_strobes", strobes, 0);
      chk("fault_sticky", int'({bus.fault, bus.fault_cause}), 4 + held_cause);
    end else begin
      n_irw += int'(bus.IRWrite);
      n_pcu += int'(bus.PCUpdate);
      n_rw  += int'(bus.RegWrite);
      n_mw  += int'(bus.MemWrite);
      n_br  += int'(bus.Branch);
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL event_missing: nothing seen by cycle %0d, expected event at cycle %0d", cyc, sbq[0].cyc);
        void'(sbq.pop_front());
        n_irw = 0; n_pcu = 0; n_rw = 0; n_mw = 0; n_br = 0;
      end
      if (bus.retire || bus.fault) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL event_unexpected: retire=%0b fault=%0b at cycle %0d, expected none", bus.retire, bus.fault, cyc);
        end else begin
          e = sbq.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_is_fault", int'(bus.fault), e.is_fault);
          if (bus.fault) begin
            chk("fault_cause", int'(bus.fault_cause), e.cause);
            held_cause = e.cause;
            fault_seen = 1'b1;
          end else begin
            chk("retire_resultsrc", int'(bus.ResultSrc), e.rs);
          end
          chk("count_irwrite", n_irw, e.irw);
          chk("count_pcupdate", n_pcu, e.pcu);
          chk("count_regwrite", n_rw, e.rw);
          chk("count_memwrite", n_mw, e.mw);
          chk("count_branch", n_br, e.br);
        end
        n_irw = 0; n_pcu = 0; n_rw = 0; n_mw = 0; n_br = 0;
      end
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // One memory access waiting w cycles; beyond WMAX it never completes.
  task automatic add_window(input int w, output bit to, output int n);
    if (w > WMAX) begin
      repeat (WMAX + 1) rdy_plan.push_back(1'b0);
      to = 1'b1;
      n  = WMAX + 1;
    end else begin
      repeat (w) rdy_plan.push_back(1'b0);
      rdy_plan.push_back(1'b1);
      to = 1'b0;
      n  = w + 1;
    end
  endtask

  task automatic add_free(input int n);
    repeat (n) rdy_plan.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic run_instr(input logic [6:0] o, input int wf, input int wd);
    exp_t e;
    bit   to;
    int   n;
    int   start;
    e = '{default: 0};
    rdy_plan.delete();
    start = cyc;
    add_window(wf, to, n);
    if (to) begin
      e.is_fault = 1; e.cause = 2;
    end else begin
      e.irw = 1; e.pcu = 1;
      add_free(1);
      case (o)
        OP_LW: begin
          add_free(1);
          add_window(wd, to, n);
          if (to) begin e.is_fault = 1; e.cause = 2; end
          else begin add_free(1); e.rw = 1; e.rs = 1; end
        end
        OP_SW: begin
          add_free(1);
          add_window(wd, to, n);
          e.mw = n;
          if (to) begin e.is_fault = 1; e.cause = 2; end
        end
        OP_R, OP_I: begin add_free(2); e.rw = 1; end
        OP_BEQ:     begin add_free(1); e.br = 1; end
        OP_JAL:     begin add_free(2); e.pcu = 2; e.rw = 1; end
        default:    begin e.is_fault = 1; e.cause = 1; end
      endcase
    end
    e.cyc = e.is_fault ? start + rdy_plan.size() : start + rdy_plan.size() - 1;
    sbq.push_back(e);
    bus.op = o;
    foreach (rdy_plan[i]) begin
      bus.mem_ready = rdy_plan[i];
      tick();
    end
    if (e.is_fault != 0) begin
      repeat (20) begin
        bus.mem_ready = 1'($urandom);
        bus.op = 7'($urandom);
        tick();
      end
      do_reset();
    end
  endtask

  function automatic int rnd_wait();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return WMAX + 1;
    if (r < 8) return 0;
    return $urandom_range(0, WMAX);
  endfunction

  logic [6:0] op_tab [10];

  initial begin
    op_tab = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL,
               7'b1111111, 7'b0000000, 7'b1100111, 7'b0110111};
    bus.op = '0; bus.mem_ready = 1'b0;
    bus2.op = '0; bus2.mem_ready = 1'b0;
    tick();
    do_reset();

    run_instr(OP_LW, 0, 0);
    run_instr(OP_SW, 0, 3);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_JAL, 0, 0);
    run_instr(OP_R, 0, 0);
    run_instr(OP_I, 2, 0);
    run_instr(7'b1111111, 0, 0);
    run_instr(OP_LW, WMAX, WMAX);
    run_instr(OP_R, WMAX + 1, 0);
    run_instr(OP_SW, 1, WMAX + 1);
    run_instr(OP_LW, 0, WMAX + 1);

    repeat (300) run_instr(op_tab[$urandom_range(0, 9)], rnd_wait(), rnd_wait());

    // Reset while a store is waiting in MEMWRITE.
    bus.op = OP_SW;
    bus.mem_ready = 1'b1;
    repeat (3) tick();
    bus.mem_ready = 1'b0;
    chk("midrst_memwrite_before", int'(bus.MemWrite), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_memwrite_drop", int'(bus.MemWrite), 0);
    chk("midrst_memreq_drop", int'(bus.mem_req), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_state_fetch", int'(bus.state_o), int'(S_FETCH));
    chk("midrst_fault_clear", int'(bus.fault), 0);
    run_instr(OP_BEQ, 0, 0);

    // Second instance: no timeout, jal and I-type disabled. Main DUT held in reset.
    rst_n = 1'b0;
    tick();
    rst2_n = 1'b1;
    bus2.op = OP_JAL;
    bus2.mem_ready = 1'b0;
    repeat (40) tick();
    chk("notimeout_state", int'(bus2.state_o), int'(S_FETCH));
    chk("notimeout_fault", int'(bus2.fault), 0);
    bus2.mem_ready = 1'b1;
    tick();
    chk("jaloff_decode", int'(bus2.state_o), int'(S_DECODE));
    tick();
    chk("jaloff_fault", int'(bus2.fault), 1);
    chk("jaloff_cause", int'(bus2.fault_cause), 1);
    repeat (20) begin
      bus2.mem_ready = 1'($urandom);
      bus2.op = 7'($urandom);
      tick();
      chk("jaloff_strobes", int'({bus2.mem_req, bus2.PCUpdate, bus2.Branch, bus2.IRWrite,
                                 bus2.RegWrite, bus2.MemWrite, bus2.retire}), 0);
    end
    chk("jaloff_cause_held", int'(bus2.fault_cause), 1);
    rst2_n = 1'b0;
    tick();
    rst2_n = 1'b1;
    bus2.op = OP_I;
    bus2.mem_ready = 1'b1;
    repeat (2) tick();
    chk("itypeoff_fault", int'({bus2.fault, bus2.fault_cause}), 5);
    bus2.op = OP_R;
    rst2_n = 1'b0;
    tick();
    rst2_n = 1'b1;
    repeat (3) tick();
    chk("itypeoff_r_ok", int'(bus2.RegWrite) + 2 * int'(bus2.retire), 3);

    tick();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
